mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester (read-only) and the data-memory requester (read/write, byte strobes) for the multi-cycle miniRV core. It keeps one outstanding transaction at a time and gives data priority, with an anti-starvation rule for fetch. It also provides a transaction timeout with error response.

Parameters:
D_STREAK_MAX, 4, consecutive contended data grants allowed before fetch is forced to win (1..15)
TIMEOUT_CYC, 255, max cycles waiting for m_rvalid after m_gnt; 0 disables timeout (0..65535)
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_gnt
i_addr  in  32  fetch word address
i_gnt  out  1  fetch request accepted (combinational, IDLE only)
i_rvalid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  32  fetch read data
d_req  in  1  data request; held with fields stable until d_gnt
d_we  in  1  1 = write
d_addr  in  32  data address
d_wdata  in  32  write data
d_wstrb  in  4  byte write strobes
d_gnt  out  1  data request accepted (combinational, IDLE only)
d_rvalid  out  1  one-cycle pulse: read data valid, or write ack
d_rdata  out  32  read data (0 for write ack)
m_req  out  1  memory request, held until m_gnt
m_we  out  1  memory write
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_wstrb  out  4  memory byte strobes (4'b0000 for reads)
m_gnt  in  1  memory accepted request
m_rvalid  in  1  memory response (read data or write done)
m_rdata  in  32  memory read data
err  out  1  one-cycle pulse with the x_rvalid of a timed-out transaction
owner  out  1  0 = fetch, 1 = data; owner of current transaction, valid while busy
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; m_req, m_we, i_rvalid, d_rvalid, err, owner, busy = 0; m_addr, m_wdata, m_wstrb, i_rdata, d_rdata = 0; streak counter = 0; timeout counter = 0. Reset mid-transaction abandons it; no rvalid is ever produced for it.
- FSM states: IDLE, ADDR, DATA.
- IDLE: winner selection is combinational:
  - Only i_req: fetch wins.
  - Only d_req: data wins.
  - Both: data wins unless streak == D_STREAK_MAX, in which case fetch wins.
  - Winner's x_gnt = 1 in this cycle. At the edge: latch the winner's fields into m_* (a fetch gives m_we=0, m_wstrb=0), set owner, go to ADDR.
- Streak counter:
  - Cleared on every fetch grant.
  - +1 (saturating at D_STREAK_MAX) on a data grant while i_req = 1.
  - Unchanged on a data grant with i_req = 0.
- ADDR: m_req = 1 (registered); m_* stable. When m_gnt = 1, at the edge: m_req to 0, timeout counter cleared, go to DATA.
- DATA: m_rvalid is only honoured in this state; memory must not respond in the m_gnt cycle. The timeout counter increments each cycle.
  - On m_rvalid = 1, at the edge: owner's x_rvalid = 1 next cycle. x_rdata = m_rdata for reads; d_rdata = 0 for writes. Go to IDLE.
  - If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC with no m_rvalid: same as a response, but x_rdata = ERR_DATA (0 for writes) and err = 1.
- x_rvalid / err are single-cycle pulses. The IDLE cycle in which x_rvalid is high may already grant a new request (back-to-back).
- Minimum latency: gnt at cycle T, m_req at T+1, m_gnt at T+1, m_rvalid at T+2, x_rvalid at T+3, next gnt possible at T+3.
- Requests are never dropped: a non-winning req stays pending, with no gnt, until granted.
- x_gnt = 0 outside IDLE regardless of req.

Test Plan:
- Single fetch: i_req, i_addr=0x0000_0040; memory gnt immediately and rvalid one cycle later with 0x0000_0513 -> i_gnt at T, m_req/m_addr=0x40 at T+1, i_rvalid=1 with i_rdata=0x0000_0513 at T+3, d_rvalid stays 0.
- Data write: d_we=1, d_addr=0x100, d_wdata=0xA5A5_A5A5, d_wstrb=4'b0011 -> m_we=1, m_wstrb=0011, m_wdata matches; on m_rvalid, d_rvalid=1 and d_rdata=0.
- Contention/starvation: i_req and d_req held high continuously with D_STREAK_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; fetch never waits for more than 4 data grants.
- m_gnt stall: hold m_gnt=0 for 5 cycles -> m_req stays 1 and m_addr/m_wdata stay constant; no x_rvalid until m_rvalid arrives after m_gnt.
- Timeout: TIMEOUT_CYC=8, data read, never assert m_rvalid -> d_rvalid=1, d_rdata=0xDEADBEEF, err=1 one cycle; FSM back to IDLE; a following fetch completes normally.
- Reset mid-op: assert rst_n=0 in DATA -> all outputs 0 immediately. A late m_rvalid after release gives no x_rvalid; the first post-reset request gets granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data has priority; fetch is forced through after a streak of contended data grants.
module mem_arbiter #(
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        err,
  output logic        owner,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [3:0]  STREAK_MAX = 4'(D_STREAK_MAX);
  localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT_CYC);
  localparam bit          TMO_ON     = (TIMEOUT_CYC != 0);

  logic [1:0]  r_state;
  logic [3:0]  r_streak;
  logic [15:0] r_tcnt;
  logic        r_owner;

  logic w_idle;
  logic w_grantI;
  logic w_grantD;
  logic w_timeout;
  logic w_done;

  // Fetch wins when alone, or when the data streak has used up its allowance.
  assign w_idle    = (r_state == S_IDLE);
  assign w_grantI  = w_idle && i_req && (!d_req || (r_streak == STREAK_MAX));
  assign w_grantD  = w_idle && d_req && !w_grantI;
  assign w_timeout = TMO_ON && (r_tcnt == TMO_LIMIT);
  assign w_done    = (r_state == S_DATA) && (m_rvalid || w_timeout);

  assign i_gnt = w_grantI;
  assign d_gnt = w_grantD;
  assign busy  = !w_idle;
  assign owner = r_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_streak <= 4'd0;
      r_tcnt   <= 16'd0;
      r_owner  <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      m_wstrb  <= 4'd0;
      i_rvalid <= 1'b0;
      i_rdata  <= 32'd0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'd0;
      err      <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantI) begin
            r_state  <= S_ADDR;
            r_owner  <= 1'b0;
            r_streak <= 4'd0;
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_addr   <= i_addr;
            m_wdata  <= 32'd0;
            m_wstrb  <= 4'd0;
          end else if (w_grantD) begin
            r_state  <= S_ADDR;
            r_owner  <= 1'b1;
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            m_wstrb  <= d_we ? d_wstrb : 4'd0;
            // Only grants that made fetch wait count towards the streak.
            if (i_req && (r_streak != STREAK_MAX)) begin
              r_streak <= r_streak + 4'd1;
            end
          end
        end
        S_ADDR: begin
          if (m_gnt) begin
            m_req   <= 1'b0;
            r_tcnt  <= 16'd0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_done) begin
            r_state <= S_IDLE;
            err     <= !m_rvalid;
            if (r_owner) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_we ? 32'd0 : (m_rvalid ? m_rdata : ERR_DATA);
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= m_rvalid ? m_rdata : ERR_DATA;
            end
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int          DMAX = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
  logic [3:0]  d_wstrb = 4'd0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        err, owner, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.D_STREAK_MAX(DMAX), .TIMEOUT_CYC(TMO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err), .owner(owner), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, phase 0 = waiting for m_gnt, 1 = waiting for data
  bit          mIdle = 1'b1, mOwner = 1'b0, mPhase = 1'b0;
  int          mWait = 0, mStreak = 0, mTimeouts = 0;
  logic [31:0] mAddr = 32'd0, mWdata = 32'd0;
  logic        mWe = 1'b0;
  logic [3:0]  mWstrb = 4'd0;
  bit          rspI = 1'b0, rspD = 1'b0, rspErr = 1'b0;
  logic [31:0] rspData = 32'd0;
  string       order = "";

  // Pending requests, applied to the DUT at the start of the next cycle
  bit          iPend = 1'b0, dPend = 1'b0;
  logic [31:0] pIaddr = 32'd0, pDaddr = 32'd0, pDwdata = 32'd0;
  logic        pDwe = 1'b0;
  logic [3:0]  pDwstrb = 4'd0;

  // Memory behaviour: 0 random, 1 always, 2 never
  int          gntMode = 1, rvMode = 1, reqPct = 0;
  bit          forceRv = 1'b0, randRdata = 1'b0;
  logic [31:0] rdataVal = 32'd0;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkString(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkBit("busy", busy, !mIdle);
    checkBit("m_req", m_req, !mIdle && !mPhase);
    checkBit("i_rvalid", i_rvalid, rspI);
    checkBit("d_rvalid", d_rvalid, rspD);
    checkBit("err", err, rspErr);
    if (rspI) checkWord("i_rdata", i_rdata, rspData);
    if (rspD) checkWord("d_rdata", d_rdata, rspData);
    if (!mIdle) begin
      checkBit("owner", owner, mOwner);
      checkWord("m_addr", m_addr, mAddr);
      checkBit("m_we", m_we, mWe);
      checkWord("m_wdata", m_wdata, mWdata);
      checkWord("m_wstrb", {28'd0, m_wstrb}, {28'd0, mWstrb});
    end
  endtask

  task automatic reqFetch(input logic [31:0] a);
    iPend = 1'b1; pIaddr = a;
  endtask

  task automatic reqData(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    dPend = 1'b1; pDwe = we; pDaddr = a; pDwdata = wd; pDwstrb = ws;
  endtask

  task automatic applyStimulus(input int nCycles);
    bit expI, expD;
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk); #1;
      checkOutput();
      if (!iPend && ($urandom_range(99) < reqPct)) reqFetch($urandom() & 32'hFFFF_FFFC);
      if (!dPend && ($urandom_range(99) < reqPct))
        reqData(1'($urandom_range(1)), $urandom(), $urandom(), 4'($urandom_range(15)));
      i_req = iPend; i_addr = pIaddr;
      d_req = dPend; d_we = pDwe; d_addr = pDaddr; d_wdata = pDwdata; d_wstrb = pDwstrb;
      m_gnt = 1'b0; m_rvalid = 1'b0;
      if (!mIdle && !mPhase) m_gnt = (gntMode == 1) || (gntMode == 0 && $urandom_range(1) == 1);
      if (!mIdle && mPhase) m_rvalid = (rvMode == 1) || (rvMode == 0 && $urandom_range(2) == 0);
      if (forceRv) begin m_rvalid = 1'b1; forceRv = 1'b0; end
      m_rdata = randRdata ? $urandom() : rdataVal;
      #1;
      expI = mIdle && iPend && (!dPend || mStreak == DMAX);
      expD = mIdle && dPend && !expI;
      checkBit("i_gnt", i_gnt, expI);
      checkBit("d_gnt", d_gnt, expD);
      rspI = 1'b0; rspD = 1'b0; rspErr = 1'b0;
      if (expI) begin
        mIdle = 1'b0; mPhase = 1'b0; mOwner = 1'b0; mAddr = i_addr;
        mWe = 1'b0; mWdata = 32'd0; mWstrb = 4'd0; mStreak = 0; iPend = 1'b0;
        order = {order, "I"};
      end else if (expD) begin
        mIdle = 1'b0; mPhase = 1'b0; mOwner = 1'b1; mAddr = d_addr;
        mWe = d_we; mWdata = d_wdata; mWstrb = d_we ? d_wstrb : 4'd0;
        if (iPend && mStreak < DMAX) mStreak++;
        dPend = 1'b0;
        order = {order, "D"};
      end else if (!mIdle && !mPhase) begin
        if (m_gnt) begin mPhase = 1'b1; mWait = 0; end
      end else if (!mIdle) begin
        if (m_rvalid || mWait == TMO) begin
          mIdle = 1'b1; rspI = !mOwner; rspD = mOwner; rspErr = !m_rvalid;
          rspData = (mOwner && mWe) ? 32'd0 : (m_rvalid ? m_rdata : ERRD);
          if (!m_rvalid) mTimeouts++;
        end else begin
          mWait++;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      applyStimulus(1);
      done = mIdle && !iPend && !dPend && !rspI && !rspD;
    end
    checkBit("drainDone", done, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_busy"}, busy, 1'b0);
    checkBit({tag, "_m_req"}, m_req, 1'b0);
    checkBit({tag, "_m_we"}, m_we, 1'b0);
    checkWord({tag, "_m_addr"}, m_addr, 32'd0);
    checkWord({tag, "_m_wdata"}, m_wdata, 32'd0);
    checkWord({tag, "_m_wstrb"}, {28'd0, m_wstrb}, 32'd0);
    checkBit({tag, "_i_rvalid"}, i_rvalid, 1'b0);
    checkBit({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    checkWord({tag, "_i_rdata"}, i_rdata, 32'd0);
    checkWord({tag, "_d_rdata"}, d_rdata, 32'd0);
    checkBit({tag, "_err"}, err, 1'b0);
    checkBit({tag, "_owner"}, owner, 1'b0);
  endtask

  initial begin
    int budget;
    int tmoBefore;
    #3;
    checkAllZero("reset");
    checkBit("reset_i_gnt", i_gnt, 1'b0);
    checkBit("reset_d_gnt", d_gnt, 1'b0);
    #9 rst_n = 1'b1;

    $display("[TB] single fetch");
    rdataVal = 32'h0000_0513;
    reqFetch(32'h0000_0040);
    drain(20);
    checkString("fetchOrder", order, "I");

    $display("[TB] data write");
    reqData(1'b1, 32'h100, 32'hA5A5_A5A5, 4'b0011);
    drain(20);
    checkString("writeOrder", order, "ID");

    $display("[TB] m_gnt stall");
    reqData(1'b0, 32'h200, 32'h1234_5678, 4'hF);
    gntMode = 2;
    applyStimulus(6);
    gntMode = 1;
    drain(20);

    $display("[TB] contention");
    order = "";
    reqPct = 100;
    budget = 0;
    while (order.len() < 10 && budget < 300) begin applyStimulus(1); budget++; end
    reqPct = 0;
    drain(50);
    checkString("grantOrder", order.substr(0, 9), "DDDDIDDDDI");

    $display("[TB] timeout");
    tmoBefore = mTimeouts;
    rvMode = 2;
    reqData(1'b0, 32'h300, 32'd0, 4'd0);
    drain(40);
    checkBit("timeoutSeen", mTimeouts == tmoBefore + 1, 1'b1);
    rvMode = 1;
    rdataVal = 32'h0000_0093;
    reqFetch(32'h0000_0044);
    drain(20);

    $display("[TB] reset mid-op");
    rvMode = 2;
    reqData(1'b0, 32'h400, 32'd0, 4'd0);
    budget = 0;
    while (!(!mIdle && mPhase) && budget < 20) begin applyStimulus(1); budget++; end
    checkBit("reachedData", !mIdle && mPhase, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    mIdle = 1'b1; mPhase = 1'b0; mStreak = 0; iPend = 1'b0; dPend = 1'b0;
    rspI = 1'b0; rspD = 1'b0; rspErr = 1'b0;
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    forceRv = 1'b1;
    applyStimulus(2);
    rvMode = 1;
    rdataVal = 32'h0000_0F0F;
    reqFetch(32'h0000_0080);
    drain(20);

    $display("[TB] random traffic");
    gntMode = 0; rvMode = 0; randRdata = 1'b1; reqPct = 40;
    applyStimulus(1500);
    reqPct = 0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
